// File: rtl/hdmi_packet_scheduler.sv
// Purpose: schedules HDMI data-island packet slots (ACR, audio sample, AVI IF, audio IF) on blanking lines.
// Latency: first slot starts 1+SLOT_OFFSET cycles after the registered hsync rising edge; slots are 32 cycles, back-to-back.
// Backpressure: none accepted downstream; a blank/enable drop aborts the island and leaves the packet pending.
module hdmi_packet_scheduler #(
    parameter int CTS         = 27000,
    parameter int MAX_PKTS    = 2,
    parameter int SLOT_OFFSET = 0
) (
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic       i_hSync,
    input  logic       i_vSync,
    input  logic       i_blank,
    input  logic       i_audio_enable,
    input  logic       i_aud_req,
    output logic       o_aud_ack,
    output logic       o_island,
    output logic       o_pkt_start,
    output logic [2:0] o_pkt_sel,
    output logic       o_first,
    output logic       o_acr_miss
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFSET = 2'd1,
        SLOT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0]  SEL_NONE = 3'd0;
    localparam logic [2:0]  SEL_ACR  = 3'd1;
    localparam logic [2:0]  SEL_AUD  = 3'd2;
    localparam logic [2:0]  SEL_AVI  = 3'd3;
    localparam logic [2:0]  SEL_AIF  = 3'd4;
    localparam logic [19:0] ACR_LAST = 20'(CTS - 1);
    localparam logic [2:0]  MAX_P    = 3'(MAX_PKTS);
    localparam logic [3:0]  OFF_LAST = 4'((SLOT_OFFSET == 0) ? 0 : SLOT_OFFSET - 1);

    // Fixed priority: ACR > audio sample > AVI infoframe > audio infoframe.
    function automatic logic [2:0] pickSrc(input logic acr, input logic aud,
                                           input logic avi, input logic aif);
        if (acr)      return SEL_ACR;
        else if (aud) return SEL_AUD;
        else if (avi) return SEL_AVI;
        else if (aif) return SEL_AIF;
        else          return SEL_NONE;
    endfunction

    state_t      state;
    state_t      stateNext;
    logic [19:0] acrCnt;
    logic        acrPend;
    logic        aviPend;
    logic        aifPend;
    logic        hsPrev;
    logic        vsPrev;
    logic [4:0]  slotCnt;
    logic [1:0]  pktIdx;
    logic [3:0]  offCnt;
    logic [2:0]  curSel;
    logic        startFirst;
    logic        startNext;

    logic        hsRise;
    logic        vsRise;
    logic        acrWrap;
    logic        abortNow;
    logic        lastCycle;
    logic        complete;
    logic        anyPend;
    logic [2:0]  nowSel;
    logic [2:0]  remSel;

    assign hsRise    = i_hSync & ~hsPrev;
    assign vsRise    = i_vSync & ~vsPrev;
    assign acrWrap   = (acrCnt == ACR_LAST);
    assign abortNow  = ((state == OFFSET) || (state == SLOT)) && (!i_blank || !i_audio_enable);
    assign lastCycle = (state == SLOT) && (slotCnt == 5'd31);
    assign complete  = lastCycle && !abortNow;
    assign anyPend   = acrPend | i_aud_req | aviPend | aifPend;
    assign nowSel    = pickSrc(acrPend, i_aud_req, aviPend, aifPend);
    // The source finishing this cycle is not a candidate for the following slot.
    assign remSel    = pickSrc(acrPend   && (curSel != SEL_ACR),
                               i_aud_req && (curSel != SEL_AUD),
                               aviPend   && (curSel != SEL_AVI),
                               aifPend   && (curSel != SEL_AIF));

    // Free-running ACR period counter; wraps at CTS-1 independent of island activity.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n)     acrCnt <= '0;
        else if (acrWrap) acrCnt <= '0;
        else              acrCnt <= acrCnt + 20'd1;
    end

    // Previous-cycle sync levels for rising-edge detection.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hsPrev <= 1'b0;
            vsPrev <= 1'b0;
        end else begin
            hsPrev <= i_hSync;
            vsPrev <= i_vSync;
        end
    end

    // Pending flags: a new request wins over a completion landing on the same edge.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acrPend <= 1'b0;
            aviPend <= 1'b0;
            aifPend <= 1'b0;
        end else begin
            acrPend <= acrWrap | (acrPend & ~(complete && curSel == SEL_ACR));
            aviPend <= vsRise  | (aviPend & ~(complete && curSel == SEL_AVI));
            aifPend <= vsRise  | (aifPend & ~(complete && curSel == SEL_AIF));
        end
    end

    // Island FSM state register.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Island FSM next-state: open on a qualified hsync edge, chain slots, abort on blank/enable loss.
    always_comb begin
        stateNext  = state;
        startFirst = 1'b0;
        startNext  = 1'b0;
        case (state)
            IDLE: begin
                if (hsRise && i_blank && i_audio_enable && anyPend) begin
                    if (SLOT_OFFSET == 0) begin
                        stateNext  = SLOT;
                        startFirst = 1'b1;
                    end else begin
                        stateNext  = OFFSET;
                    end
                end
            end
            OFFSET: begin
                if (abortNow) begin
                    stateNext = IDLE;
                end else if (offCnt == OFF_LAST) begin
                    if (nowSel != SEL_NONE) begin
                        stateNext  = SLOT;
                        startFirst = 1'b1;
                    end else begin
                        stateNext  = IDLE;
                    end
                end
            end
            SLOT: begin
                if (abortNow) begin
                    stateNext = IDLE;
                end else if (lastCycle) begin
                    if ((({1'b0, pktIdx} + 3'd1) < MAX_P) && (remSel != SEL_NONE)) begin
                        startNext = 1'b1;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Slot bookkeeping: cycle-in-slot, slot index, frozen source, offset delay.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slotCnt <= '0;
            pktIdx  <= '0;
            curSel  <= SEL_NONE;
            offCnt  <= '0;
        end else begin
            offCnt <= (state == OFFSET) ? offCnt + 4'd1 : 4'd0;
            if (startFirst) begin
                slotCnt <= '0;
                pktIdx  <= '0;
                curSel  <= nowSel;
            end else if (startNext) begin
                slotCnt <= '0;
                pktIdx  <= pktIdx + 2'd1;
                curSel  <= remSel;
            end else if (state == SLOT) begin
                slotCnt <= slotCnt + 5'd1;
            end
        end
    end

    // Output decode from registered state so an async reset clears everything at once.
    always_comb begin
        o_island    = 1'b0;
        o_pkt_start = 1'b0;
        o_pkt_sel   = SEL_NONE;
        o_first     = 1'b0;
        o_aud_ack   = 1'b0;
        o_acr_miss  = 1'b0;
        if (state == SLOT) begin
            o_island    = 1'b1;
            o_pkt_start = (slotCnt == 5'd0);
            o_pkt_sel   = curSel;
            o_first     = (pktIdx == 2'd0);
        end
        o_aud_ack  = complete && (curSel == SEL_AUD);
        o_acr_miss = acrWrap && acrPend && !(complete && curSel == SEL_ACR);
    end

endmodule

// File: doc/hdmi_packet_scheduler.md
# hdmi_packet_scheduler

Sequences HDMI data-island packets for the HDMI audio/infoframe encoder. Tracks pending packet sources (audio clock regeneration, audio sample, AVI infoframe, audio infoframe), opens a data island on each blanking line, and grants up to `MAX_PKTS` back-to-back 32-cycle packet slots by fixed priority. It sits between the video timing generator and the packet serializer/TERC4 encoder, in the pixel clock domain.

## Interface
- `CTS`, 27000: pixel clocks per ACR packet request.
- `MAX_PKTS`, 2: max packets per island (1..4).
- `SLOT_OFFSET`, 0: idle cycles between hsync edge and first slot (0..15).
- `i_pixclk` in 1: pixel clock; all logic on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_hSync` in 1: horizontal sync, active high.
- `i_vSync` in 1: vertical sync, active high.
- `i_blank` in 1: video blanking, high outside active area.
- `i_audio_enable` in 1: gates island generation.
- `i_aud_req` in 1: level; audio sample packet ready in upstream buffer.
- `o_aud_ack` out 1: 1-cycle pulse; audio packet fully sent.
- `o_island` out 1: high for every cycle of an island.
- `o_pkt_start` out 1: 1-cycle pulse on first cycle of each slot.
- `o_pkt_sel` out 3: 0 none, 1 ACR, 2 audio sample, 3 AVI IF, 4 audio IF; held for whole slot.
- `o_first` out 1: high during first slot of an island.
- `o_acr_miss` out 1: 1-cycle pulse; ACR request arrived while still pending.

## Operation
- Reset: all outputs 0, pending flags 0, ACR counter 0, FSM IDLE.
- ACR counter: 20-bit, increments every cycle regardless of enable; at CTS-1 wraps to 0 and sets `acr_pend`; if already set, pulse `o_acr_miss`, flag stays set.
- Infoframe flags: rising edge of `i_vSync` (registered compare) sets `avi_pend` and `aif_pend`.
- Audio pending = `i_aud_req` sampled at slot start.
- Priority at each slot start: ACR > audio > AVI > AIF. Chosen source frozen into `o_pkt_sel` for 32 cycles.
- Pending flag (or `o_aud_ack`) clears/pulses only in slot's last cycle (count 31); interrupted packets remain pending.
- FSM states: IDLE, OFFSET, SLOT, DONE.
  - IDLE -> OFFSET (or SLOT if SLOT_OFFSET=0): registered `i_hSync` rising edge while `i_blank`=1, `i_audio_enable`=1, and at least one source pending.
  - OFFSET -> SLOT after SLOT_OFFSET cycles; if nothing pending then, -> IDLE with no island.
  - SLOT -> SLOT at count 31 if packets sent < MAX_PKTS and a source pending (excluding the one just completing); else -> DONE.
  - DONE -> IDLE next cycle (`o_island` low in DONE).
- Abort: `i_blank` low or `i_audio_enable` low in SLOT/OFFSET -> IDLE next cycle, `o_island`/`o_pkt_sel` to 0, no flag cleared, no ack.
- At most one island per line; second hsync edge during an island ignored.

## Timing
- Edge sampled at cycle E (`i_hSync`=1, prev 0): `o_island`, `o_pkt_start`, `o_first` high at E+1+SLOT_OFFSET.
- Slot n starts at E+1+SLOT_OFFSET+32n; back-to-back, no gap.
- `o_island` falls the cycle after last slot's count 31.
- `o_aud_ack`, flag clear coincide with count 31 of the slot.
- ACR set on the same edge counter wraps; if wrap coincides with ACR slot completion, the flag stays set (set wins), no miss pulse.
- vsync edge coinciding with AVI/AIF completion: flag stays set.
- Async reset mid-island: outputs drop immediately.

## Test plan
- CTS=100, no audio, blank lines with hsync: ACR pending every 100 cycles; island with `o_pkt_sel`=1, `o_pkt_start` at E+1, `o_island` 32 cycles.
- vsync edge then 2 blank lines, MAX_PKTS=2, `i_aud_req`=1: line 1 slots = audio(2), AVI(3); line 2 = audio(2), AIF(4); `o_aud_ack` at each audio slot's cycle 31.
- ACR and all sources pending, MAX_PKTS=4: slots 1,2,3,4 back-to-back, `o_first` only on first, `o_island` exactly 128 cycles.
- `i_blank` falls at slot cycle 10: `o_island` low next cycle, flag remains, same packet re-sent next line.
- CTS=50 with no blanking lines for 120 cycles: `o_acr_miss` pulses at cycle 99 and once more later, one ACR sent afterwards.
- `i_rst_n` low mid-slot: all outputs 0 asynchronously; after release, ACR counter restarts from 0, first request at cycle CTS-1.
